// File: rtl/rtu_req_rr_arbiter_if.sv
// Request/response bundle between the per-port RTU requesters, the RTU match engine
// and the round-robin arbiter. The slave modport is the arbiter's view of the bundle.
interface rtu_req_rr_arbiter_if #(
  parameter int g_num_ports  = 7,
  parameter int g_req_width  = 112,
  parameter int g_mask_width = 32,
  parameter int g_port_w     = (g_num_ports > 1) ? $clog2(g_num_ports) : 1
) ();
  logic [g_num_ports-1:0]             port_req_i;
  logic [g_num_ports*g_req_width-1:0] port_req_data_i;
  logic [g_num_ports-1:0]             port_ack_o;
  logic [g_mask_width-1:0]            rsp_mask_o;
  logic                               rsp_drop_o;

  logic                               eng_req_o;
  logic [g_req_width-1:0]             eng_req_data_o;
  logic [g_port_w-1:0]                eng_req_port_o;
  logic                               eng_abort_o;
  logic                               eng_rsp_valid_i;
  logic [g_mask_width-1:0]            eng_rsp_mask_i;
  logic                               eng_rsp_drop_i;
  logic                               timeout_o;

  modport master (
    output port_req_i, port_req_data_i, eng_rsp_valid_i, eng_rsp_mask_i, eng_rsp_drop_i,
    input  port_ack_o, rsp_mask_o, rsp_drop_o, eng_req_o, eng_req_data_o, eng_req_port_o,
           eng_abort_o, timeout_o
  );

  modport slave (
    input  port_req_i, port_req_data_i, eng_rsp_valid_i, eng_rsp_mask_i, eng_rsp_drop_i,
    output port_ack_o, rsp_mask_o, rsp_drop_o, eng_req_o, eng_req_data_o, eng_req_port_o,
           eng_abort_o, timeout_o
  );
endinterface

// File: rtl/rtu_req_rr_arbiter.sv
// Round-robin arbiter sharing one RTU match engine among the lookup requesters,
// with a bounded per-lookup wait so a stalled engine cannot block ingress.
module rtu_req_rr_arbiter #(
  parameter int g_num_ports  = 7,
  parameter int g_req_width  = 112,
  parameter int g_mask_width = 32,
  parameter int g_timeout    = 64
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic [g_num_ports-1:0] port_en_i,
  rtu_req_rr_arbiter_if.slave    bus
);
  localparam int c_port_w  = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;
  localparam int c_timer_w = $clog2(g_timeout + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [c_port_w-1:0]     idx_q, idx_d;
  logic [c_port_w-1:0]     last_q, last_d;
  logic [g_req_width-1:0]  data_q, data_d;
  logic [c_timer_w-1:0]    timer_q, timer_d;
  logic                    eng_req_q, eng_req_d;
  logic [g_num_ports-1:0]  ack_q, ack_d;
  logic [g_mask_width-1:0] mask_q, mask_d;
  logic                    drop_q, drop_d;
  logic                    abort_q, abort_d;
  logic                    timeout_q, timeout_d;

  logic [g_req_width-1:0]  req_data [g_num_ports];
  logic [g_num_ports-1:0]  req_v;
  logic                    found;
  logic [c_port_w-1:0]     sel_idx;
  logic [g_req_width-1:0]  sel_data;
  int                      scan;

  // Scan starts just after the last granted port, so a port that was just served ranks last.
  always_comb begin
    req_v    = bus.port_req_i & port_en_i;
    found    = 1'b0;
    sel_idx  = '0;
    sel_data = '0;
    scan     = 0;
    for (int i = 0; i < g_num_ports; i++) begin
      req_data[i] = bus.port_req_data_i[i*g_req_width +: g_req_width];
    end
    for (int off = 1; off <= g_num_ports; off++) begin
      scan = (int'(last_q) + off) % g_num_ports;
      if (!found && req_v[c_port_w'(scan)]) begin
        found    = 1'b1;
        sel_idx  = c_port_w'(scan);
        sel_data = req_data[c_port_w'(scan)];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    data_d    = data_q;
    timer_d   = timer_q;
    eng_req_d = 1'b0;
    ack_d     = '0;
    mask_d    = '0;
    drop_d    = 1'b0;
    abort_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_i && found) begin
          idx_d     = sel_idx;
          data_d    = sel_data;
          eng_req_d = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response on the expiry cycle still counts as a real answer.
        if (bus.eng_rsp_valid_i) begin
          mask_d       = bus.eng_rsp_mask_i;
          drop_d       = bus.eng_rsp_drop_i;
          ack_d[idx_q] = 1'b1;
          state_d      = S_RESP;
        end else if (timer_q == c_timer_w'(g_timeout - 1)) begin
          drop_d       = 1'b1;
          abort_d      = 1'b1;
          timeout_d    = 1'b1;
          ack_d[idx_q] = 1'b1;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + c_timer_w'(1);
        end
      end
      S_RESP: begin
        last_d  = idx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= c_port_w'(g_num_ports - 1);
      data_q    <= '0;
      timer_q   <= '0;
      eng_req_q <= 1'b0;
      ack_q     <= '0;
      mask_q    <= '0;
      drop_q    <= 1'b0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      data_q    <= data_d;
      timer_q   <= timer_d;
      eng_req_q <= eng_req_d;
      ack_q     <= ack_d;
      mask_q    <= mask_d;
      drop_q    <= drop_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.eng_req_o      = eng_req_q;
  assign bus.eng_req_data_o = data_q;
  assign bus.eng_req_port_o = idx_q;
  assign bus.port_ack_o     = ack_q;
  assign bus.rsp_mask_o     = mask_q;
  assign bus.rsp_drop_o     = drop_q;
  assign bus.eng_abort_o    = abort_q;
  assign bus.timeout_o      = timeout_q;
endmodule

// File: tb/tb_rtu_req_rr_arbiter.sv
// Directed bench for rtu_req_rr_arbiter: stimulus pushes expected grants/acks into
// queues, a negedge monitor pops and compares them; a small engine model answers lookups.
module tb_rtu_req_rr_arbiter;
  localparam int NP = 7;
  localparam int RW = 112;
  localparam int MW = 32;
  localparam int TO = 64;

  typedef struct {
    int port;
    int at;
  } grant_t;

  typedef struct {
    int          port;
    logic [31:0] mask;
    logic        drop;
    logic        tmo;
    int          at;
  } ack_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [NP-1:0] port_en;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  grant_t gq[$];
  ack_t   aq[$];
  grant_t g;
  ack_t   a;

  int          eng_dly  [NP];
  logic [31:0] eng_mask [NP];
  logic        eng_drop [NP];

  rtu_req_rr_arbiter_if #(.g_num_ports(NP), .g_req_width(RW), .g_mask_width(MW)) bus ();

  rtu_req_rr_arbiter #(
    .g_num_ports(NP), .g_req_width(RW), .g_mask_width(MW), .g_timeout(TO)
  ) dut (
    .clk_sys_i(clk),
    .rst_n_i  (rst_n),
    .en_i     (en),
    .port_en_i(port_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RW-1:0] pay(input int p);
    logic [RW-1:0] v;
    for (int i = 0; i < RW / 16; i++) v[i*16 +: 16] = 16'hC0DE ^ (16'(p) * 16'h1111) ^ 16'(i);
    return v;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name, input int val);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %0d, expected none (cycle %0d)", name, val, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ack"},      bus.port_ack_o, 0);
    check_output({tag, "_mask"},     bus.rsp_mask_o, 0);
    check_output({tag, "_drop"},     bus.rsp_drop_o, 0);
    check_output({tag, "_eng_req"},  bus.eng_req_o, 0);
    check_output({tag, "_eng_data"}, bus.eng_req_data_o, 0);
    check_output({tag, "_eng_port"}, bus.eng_req_port_o, 0);
    check_output({tag, "_abort"},    bus.eng_abort_o, 0);
    check_output({tag, "_timeout"},  bus.timeout_o, 0);
  endtask

  task automatic push_grant(input int p, input int at);
    gq.push_back('{port: p, at: at});
  endtask

  task automatic push_ack(input int p, input logic [31:0] m, input logic d, input logic t, input int at);
    aq.push_back('{port: p, mask: m, drop: d, tmo: t, at: at});
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Requesters drop their level on ack; returns after n acks or flags an expired budget.
  task automatic wait_acks(input int n, input int budget);
    int seen = 0;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (bus.port_ack_o != '0) begin
        seen++;
        bus.port_req_i &= ~bus.port_ack_o;
      end
    end
    if (seen < n) report_fail("ack_wait_expired", seen);
  endtask

  task automatic wait_grants(input int n, input int budget, input bit clear_on_last);
    int seen = 0;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (bus.eng_req_o) begin
        seen++;
        if (seen == n && clear_on_last) bus.port_req_i = '0;
      end
    end
    if (seen < n) report_fail("grant_wait_expired", seen);
  endtask

  // Engine model: answers each strobe after a per-port delay; negative delay never answers.
  initial begin
    int p;
    int d;
    bus.eng_rsp_valid_i = 1'b0;
    bus.eng_rsp_mask_i  = '0;
    bus.eng_rsp_drop_i  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.eng_req_o) begin
        p = int'(bus.eng_req_port_o);
        d = (p < NP) ? eng_dly[p] : -1;
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1;
          bus.eng_rsp_valid_i = 1'b1;
          bus.eng_rsp_mask_i  = eng_mask[p];
          bus.eng_rsp_drop_i  = eng_drop[p];
          @(posedge clk);
          #1;
          bus.eng_rsp_valid_i = 1'b0;
          bus.eng_rsp_mask_i  = '0;
          bus.eng_rsp_drop_i  = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.eng_req_o) begin
      if (gq.size() == 0) report_fail("grant_unexpected", int'(bus.eng_req_port_o));
      else begin
        g = gq.pop_front();
        check_output("grant_port",  bus.eng_req_port_o, g.port);
        check_output("grant_data",  bus.eng_req_data_o, pay(g.port));
        check_output("grant_cycle", cyc, g.at);
      end
    end
    if (bus.port_ack_o != '0) begin
      if (aq.size() == 0) report_fail("ack_unexpected", int'(bus.port_ack_o));
      else begin
        a = aq.pop_front();
        check_output("ack_vector",  bus.port_ack_o, NP'(1) << a.port);
        check_output("ack_mask",    bus.rsp_mask_o, a.mask);
        check_output("ack_drop",    bus.rsp_drop_o, a.drop);
        check_output("ack_timeout", bus.timeout_o, a.tmo);
        check_output("ack_abort",   bus.eng_abort_o, a.tmo);
        check_output("ack_cycle",   cyc, a.at);
      end
    end else if (bus.timeout_o || bus.eng_abort_o) begin
      report_fail("stray_timeout_or_abort", cyc);
    end
  end

  initial begin
    repeat (3000) @(posedge clk);
    $display("[TB] FAIL watchdog: run did not finish within 3000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : apply_stimulus
    int e;
    rst_n   = 1'b0;
    en      = 1'b1;
    port_en = '1;
    bus.port_req_i = '0;
    for (int i = 0; i < NP; i++) begin
      bus.port_req_data_i[i*RW +: RW] = pay(i);
      eng_dly[i]  = 1;
      eng_mask[i] = 32'h100 << i;
      eng_drop[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    sync();
    rst_n = 1'b1;

    // All ports request continuously: grants 0..6 then 0 again, one lookup per 4 cycles.
    sync();
    e = cyc;
    bus.port_req_i = '1;
    for (int k = 0; k < 8; k++) begin
      push_grant(k % NP, e + 1 + 4 * k);
      push_ack(k % NP, 32'h100 << (k % NP), 1'b0, 1'b0, e + 3 + 4 * k);
    end
    wait_grants(8, 100, 1'b1);
    wait_acks(1, 20);

    // Single request on port 3, engine answers two cycles after the strobe.
    sync();
    e = cyc;
    eng_dly[3]  = 2;
    eng_mask[3] = 32'h10;
    bus.port_req_i = NP'(1) << 3;
    push_grant(3, e + 1);
    push_ack(3, 32'h10, 1'b0, 1'b0, e + 4);
    wait_acks(1, 20);
    eng_dly[3]  = 1;
    eng_mask[3] = 32'h100 << 3;

    // Engine silent for port 1: timeout ack, then port 2 is served normally.
    sync();
    e = cyc;
    eng_dly[1] = -1;
    bus.port_req_i = NP'(7'b0000110);
    push_grant(1, e + 1);
    push_ack(1, 32'h0, 1'b1, 1'b1, e + 66);
    push_grant(2, e + 68);
    push_ack(2, 32'h400, 1'b0, 1'b0, e + 70);
    wait_acks(2, 120);
    eng_dly[1] = 1;

    // Response on the very cycle the timer expires wins over the timeout.
    sync();
    e = cyc;
    eng_dly[1]  = TO;
    eng_mask[1] = 32'hCAFE0001;
    bus.port_req_i = NP'(7'b0000010);
    push_grant(1, e + 1);
    push_ack(1, 32'hCAFE0001, 1'b0, 1'b0, e + 66);
    wait_acks(1, 120);
    eng_dly[1]  = 1;
    eng_mask[1] = 32'h100 << 1;

    // Port 2 disabled: only port 5 is served although port 2 ranks first.
    sync();
    e = cyc;
    port_en = NP'(7'b1111011);
    eng_drop[5] = 1'b1;
    bus.port_req_i = NP'(7'b0100100);
    push_grant(5, e + 1);
    push_ack(5, 32'h2000, 1'b1, 1'b0, e + 3);
    wait_acks(1, 20);
    repeat (20) @(negedge clk);
    bus.port_req_i = '0;
    port_en = '1;
    eng_drop[5] = 1'b0;

    // Global enable dropped mid-lookup: current lookup finishes, port 0 is never granted.
    sync();
    e = cyc;
    eng_dly[6] = 3;
    bus.port_req_i = NP'(7'b1000001);
    push_grant(6, e + 1);
    push_ack(6, 32'h4000, 1'b0, 1'b0, e + 5);
    wait_grants(1, 10, 1'b0);
    en = 1'b0;
    wait_acks(1, 20);
    repeat (20) @(negedge clk);
    bus.port_req_i = '0;
    en = 1'b1;
    eng_dly[6] = 1;

    // Serve port 2 so the pointer would favour port 5 if reset failed to restore it.
    sync();
    e = cyc;
    bus.port_req_i = NP'(7'b0000100);
    push_grant(2, e + 1);
    push_ack(2, 32'h400, 1'b0, 1'b0, e + 3);
    wait_acks(1, 20);

    // Reset during WAIT: silent abandon, late response ignored, port 0 first afterwards.
    sync();
    e = cyc;
    eng_dly[3] = 4;
    bus.port_req_i = NP'(7'b0001000);
    push_grant(3, e + 1);
    wait_grants(1, 10, 1'b0);
    sync();
    rst_n = 1'b0;
    bus.port_req_i = '0;
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    repeat (6) @(negedge clk);
    eng_dly[3] = 1;
    sync();
    e = cyc;
    bus.port_req_i = NP'(7'b0100001);
    push_grant(0, e + 1);
    push_ack(0, 32'h100, 1'b0, 1'b0, e + 3);
    push_grant(5, e + 5);
    push_ack(5, 32'h2000, 1'b0, 1'b0, e + 7);
    wait_acks(2, 40);

    repeat (5) @(negedge clk);
    check_output("grants_left", gq.size(), 0);
    check_output("acks_left", aq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
